// File: rtl/tow_pkg.sv
// Shared definitions for the pushbutton conditioner: FSM state encoding and
// default debounce sizing.
package tow_pkg;

  // Debounce FSM states; encoding is fixed so other blocks can decode it.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } pb_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
  localparam int unsigned CNT_W_DEF           = 16;

endpackage

// File: rtl/pb_conditioner_if.sv
// Pushbutton conditioner signal bundle: raw button inputs plus conditioned
// press pulses and debounced levels. The slave side is the conditioner.
interface pb_conditioner_if;

  logic pbl_raw;
  logic pbr_raw;
  logic pbl;
  logic pbr;
  logic pbl_level;
  logic pbr_level;

  modport master (
    output pbl_raw, pbr_raw,
    input  pbl, pbr, pbl_level, pbr_level
  );

  modport slave (
    input  pbl_raw, pbr_raw,
    output pbl, pbr, pbl_level, pbr_level
  );

endinterface

// File: rtl/pb_channel.sv
// One pushbutton channel: optional 2-flop synchronizer, debounce counter and
// IDLE/PRESS_WAIT/HELD/REL_WAIT FSM producing a one-cycle press pulse and a
// debounced level. Define PB_SYNC_EN to insert the synchronizer; without it
// the raw input is sampled directly (synchronous stimulus only).
module pb_channel
  import tow_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if ((DEBOUNCE_CYCLES < 2) || ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)))
  begin : g_bad_param
    $error("pb_channel: DEBOUNCE_CYCLES must be >= 2 and fit in CNT_W bits");
  end

  logic sample;

`ifdef PB_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the raw level into the two-stage synchronizer.
  always_comb begin
    sync_d = {sync_q[0], raw};
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= sync_d;
  end

  assign sample = sync_q[1];
`else
  assign sample = raw;
`endif

  pb_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;

  // Next-state, counter and output decode; counter is cleared whenever a
  // qualification window ends and never advances past CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sample) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sample) begin
          state_d = REL_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      REL_WAIT: begin
        if (sample) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == REL_WAIT);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  assign pulse = pulse_q;
  assign level = level_q;

endmodule

// File: rtl/pb_conditioner.sv
// Pushbutton conditioner top: two independent, identical pb_channel
// instances for the left and right buttons. Define PB_SYNC_EN to add a
// 2-flop input synchronizer in each channel.
module pb_conditioner
  import tow_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input logic              clk,
  input logic              rst,
  pb_conditioner_if.slave  pb
);

  pb_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_left (
    .clk   (clk),
    .rst   (rst),
    .raw   (pb.pbl_raw),
    .pulse (pb.pbl),
    .level (pb.pbl_level)
  );

  pb_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_right (
    .clk   (clk),
    .rst   (rst),
    .raw   (pb.pbr_raw),
    .pulse (pb.pbr),
    .level (pb.pbr_level)
  );

endmodule

// File: tb/tb_pb_conditioner.sv
// Directed bench for pb_conditioner with DEBOUNCE_CYCLES=4. Expected latency
// follows the build: 4 edges plus 2 when PB_SYNC_EN is defined.
module tb_pb_conditioner;

  localparam int unsigned D = 4;
`ifdef PB_SYNC_EN
  localparam int unsigned SYNC_LAT = 2;
`else
  localparam int unsigned SYNC_LAT = 0;
`endif
  localparam int unsigned PLAT = D + SYNC_LAT;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pb_conditioner_if pif();

  pb_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .pb  (pif)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {pbl, pbr, pbl_level, pbr_level}.
  logic [3:0] outs;
  assign outs = {pif.pbl, pif.pbr, pif.pbl_level, pif.pbr_level};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance n cycles, checking all outputs after each edge.
  task automatic expect_for(input string tag, input int n, input logic [3:0] exp);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, outs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    pif.pbl_raw = 1'b0;
    pif.pbr_raw = 1'b0;
    #2;
    // Reset with both buttons pressed: everything stays low.
    rst = 1'b0;
    pif.pbl_raw = 1'b1;
    pif.pbr_raw = 1'b1;
    #1;
    check("reset_async", outs, 4'b0000);
    expect_for("reset_hold", 4, 4'b0000);
    pif.pbl_raw = 1'b0;
    pif.pbr_raw = 1'b0;
    expect_for("reset_idle", 3, 4'b0000);
    rst = 1'b1;
    expect_for("idle", 3, 4'b0000);

    // Clean press, held 10 cycles.
    pif.pbl_raw = 1'b1;
    expect_for("clean_wait", PLAT - 1, 4'b0000);
    expect_for("clean_pulse", 1, 4'b1010);
    expect_for("clean_held", 10 - PLAT, 4'b0010);
    pif.pbl_raw = 1'b0;
    expect_for("clean_rel_wait", PLAT - 1, 4'b0010);
    expect_for("clean_idle", 3, 4'b0000);

    // Bounce: 1 for 2, 0 for 1, then 1 for 8.
    pif.pbl_raw = 1'b1;
    expect_for("bounce_burst", 2, 4'b0000);
    pif.pbl_raw = 1'b0;
    expect_for("bounce_gap", 1, 4'b0000);
    pif.pbl_raw = 1'b1;
    expect_for("bounce_wait", PLAT - 1, 4'b0000);
    expect_for("bounce_pulse", 1, 4'b1010);
    expect_for("bounce_held", 8 - PLAT, 4'b0010);
    pif.pbl_raw = 1'b0;
    expect_for("bounce_rel_wait", PLAT - 1, 4'b0010);
    expect_for("bounce_idle", 2, 4'b0000);

    // Tie: both buttons rise on the same edge.
    pif.pbl_raw = 1'b1;
    pif.pbr_raw = 1'b1;
    expect_for("tie_wait", PLAT - 1, 4'b0000);
    expect_for("tie_pulse", 1, 4'b1111);
    expect_for("tie_held", 2, 4'b0011);
    pif.pbl_raw = 1'b0;
    pif.pbr_raw = 1'b0;
    expect_for("tie_rel_wait", PLAT - 1, 4'b0011);
    expect_for("tie_idle", 2, 4'b0000);

    // Long hold of 50 cycles, release, then re-press.
    pif.pbl_raw = 1'b1;
    expect_for("long_wait", PLAT - 1, 4'b0000);
    expect_for("long_pulse", 1, 4'b1010);
    expect_for("long_held", 50 - PLAT, 4'b0010);
    pif.pbl_raw = 1'b0;
    expect_for("long_rel_wait", PLAT - 1, 4'b0010);
    expect_for("long_idle", 1, 4'b0000);
    pif.pbl_raw = 1'b1;
    expect_for("repress_wait", PLAT - 1, 4'b0000);
    expect_for("repress_pulse", 1, 4'b1010);
    expect_for("repress_held", 2, 4'b0010);
    pif.pbl_raw = 1'b0;
    expect_for("repress_rel_wait", PLAT - 1, 4'b0010);
    expect_for("repress_idle", 2, 4'b0000);

    // Reset one cycle after PRESS_WAIT entry, right button held throughout.
    pif.pbr_raw = 1'b1;
    expect_for("rmp_pre", SYNC_LAT + 2, 4'b0000);
    rst = 1'b0;
    #1;
    check("rmp_async", outs, 4'b0000);
    expect_for("rmp_in_reset", 3, 4'b0000);
    rst = 1'b1;
    expect_for("rmp_requal", PLAT - 1, 4'b0000);
    expect_for("rmp_pulse", 1, 4'b0101);
    expect_for("rmp_held", 2, 4'b0001);
    pif.pbr_raw = 1'b0;
    expect_for("rmp_rel_wait", PLAT - 1, 4'b0001);
    expect_for("rmp_idle", 1, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pb_conditioner.md
PB_CONDITIONER -- requirements
Module: pb_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16; consecutive stable samples needed to accept a level change; legal range 2..65535.
REQ-002 SHALL have parameter CNT_W, default 16; debounce counter width; SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous reset, active-low.
REQ-005 pbl_raw  in  1  left pushbutton, asynchronous, may bounce.
REQ-006 pbr_raw  in  1  right pushbutton, asynchronous, may bounce.
REQ-007 pbl  out  1  left press pulse, one clk wide; drives tow.pbl.
REQ-008 pbr  out  1  right press pulse, one clk wide; drives tow.pbr.
REQ-009 pbl_level  out  1  debounced left button level.
REQ-010 pbr_level  out  1  debounced right button level.

Function
REQ-011 Left and right channels SHALL be fully independent and identical; no arbitration between them.
REQ-012 Per-channel FSM SHALL have states IDLE, PRESS_WAIT, HELD, REL_WAIT.
REQ-013 IDLE: sample=1 -> PRESS_WAIT, counter loads 1. Sample=0 -> stay.
REQ-014 PRESS_WAIT: sample=1 -> counter increments. Sample=0 -> IDLE, counter cleared.
REQ-015 PRESS_WAIT with counter = DEBOUNCE_CYCLES-1 and sample=1 -> HELD; pulse SHALL be high for exactly the first cycle in HELD.
REQ-016 HELD: sample=0 -> REL_WAIT, counter loads 1. Sample=1 -> stay; no further pulses however long held.
REQ-017 REL_WAIT: sample=0 -> counter increments; reaching DEBOUNCE_CYCLES-1 with sample=0 -> IDLE. Sample=1 -> HELD with no pulse.
REQ-018 Level output SHALL be 1 in HELD and REL_WAIT, and 0 in IDLE and PRESS_WAIT.
REQ-019 Latency: pulse SHALL rise DEBOUNCE_CYCLES edges after the first edge at which the sample is 1, with the sample 1 at every edge in between.
REQ-020 Simultaneous qualified presses on both channels SHALL produce both pulses in the same cycle, so tow sees a tie.
REQ-021 Counter SHALL never wrap; it saturates at DEBOUNCE_CYCLES-1.
REQ-022 Outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-023 While rst=0: both FSMs SHALL be in IDLE, counters 0, synchronizer flops 0, and pbl, pbr, pbl_level, pbr_level all 0.
REQ-024 Assertion of rst mid-PRESS_WAIT or mid-HELD SHALL discard progress; a button held through rst deassertion SHALL need a full DEBOUNCE_CYCLES qualification before pulsing.

Configuration
REQ-025 Macro PB_SYNC_EN defined: each raw input SHALL pass through a 2-flop synchronizer before the FSM, adding 2 cycles to the REQ-019 latency.
REQ-026 PB_SYNC_EN undefined: the FSM SHALL sample raw inputs directly, with no added latency; only for synchronous test benches.

Structure
REQ-027 Shared package tow_pkg SHALL hold the FSM state encoding (2 bits: IDLE=0, PRESS_WAIT=1, HELD=2, REL_WAIT=3) and DEBOUNCE_CYCLES default constant.
REQ-028 Per-channel logic SHALL be sub-module pb_channel (synchronizer, counter, FSM), instantiated twice by pb_conditioner.

Verification
All scenarios use DEBOUNCE_CYCLES=4 with PB_SYNC_EN defined.
REQ-029 Reset: rst=0 with pbl_raw=pbr_raw=1 -> all four outputs 0 throughout reset.
REQ-030 Clean press: pbl_raw=1 held 10 cycles -> pbl high exactly one cycle, 6 edges after the rise; pbl_level=1 from that cycle; pbr stays 0.
REQ-031 Bounce: pbl_raw 1 for 2 cycles, 0 for 1, then 1 for 8 -> exactly one pulse, 6 edges after the second rise; no pulse from the first burst.
REQ-032 Tie: pbl_raw and pbr_raw rise on the same edge -> pbl and pbr both high in the same single cycle.
REQ-033 Long hold: pbl_raw=1 for 50 cycles, then 0 -> one pulse only; pbl_level falls 4+2 edges after release; re-press after that -> second pulse.
REQ-034 Reset mid-press: rst=0 asserted 1 cycle after PRESS_WAIT entry, released with pbr_raw still 1 -> no pulse before reset; pulse 6 edges after rst deassertion.
